// File: rtl/and_request_dispatch_if.sv
// AND request dispatch bus: request in, terminal result out,
// computed-table miss out, plus statistics counters.
interface and_request_dispatch_if #(
  parameter int IDX_W = 30,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] req_f;
  logic [IDX_W-1:0] req_g;
  logic [TAG_W-1:0] req_tag;

  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_value;
  logic [TAG_W-1:0] res_tag;

  logic             miss_valid;
  logic             miss_ready;
  logic [IDX_W-1:0] miss_f;
  logic [IDX_W-1:0] miss_g;
  logic [TAG_W-1:0] miss_tag;

  logic             cnt_clear;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  modport master (
    output req_valid, req_f, req_g, req_tag,
    input  req_ready,
    input  res_valid, res_value, res_tag,
    output res_ready,
    input  miss_valid, miss_f, miss_g, miss_tag,
    output miss_ready,
    output cnt_clear,
    input  hit_count, miss_count
  );

  modport slave (
    input  req_valid, req_f, req_g, req_tag,
    output req_ready,
    output res_valid, res_value, res_tag,
    input  res_ready,
    output miss_valid, miss_f, miss_g, miss_tag,
    input  miss_ready,
    input  cnt_clear,
    output hit_count, miss_count
  );
endinterface

// File: rtl/and_request_dispatch.sv
// Single-entry BDD AND dispatcher: terminal cases answered directly,
// others canonicalised (min,max) and forwarded to the computed table.
module and_request_dispatch #(
  parameter int IDX_W = 30,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16,
  parameter logic [IDX_W-1:0] BDD_ZERO = '0,
  parameter logic [IDX_W-1:0] BDD_ONE  = IDX_W'(1)
) (
  input  logic clk,
  input  logic reset,
  and_request_dispatch_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY,
    RES_PEND,
    MISS_PEND
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] res_value_q, res_value_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [IDX_W-1:0] miss_f_q, miss_f_d;
  logic [IDX_W-1:0] miss_g_q, miss_g_d;
  logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic             res_fire;
  logic             miss_fire;
  logic             req_ready;
  logic             req_fire;
  logic             is_zero;
  logic             is_f;
  logic             is_g;
  logic             hit;
  logic [IDX_W-1:0] term_val;
  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] hi_idx;

  assign res_fire  = (state_q == RES_PEND) && bus.res_ready;
  assign miss_fire = (state_q == MISS_PEND) && bus.miss_ready;
  assign req_ready = (state_q == EMPTY) || res_fire || miss_fire;
  assign req_fire  = bus.req_valid && req_ready;

  // complement edge lives in the LSB: f and !f differ only there
  always_comb begin
    is_zero = (bus.req_f == BDD_ZERO) ||
              (bus.req_g == BDD_ZERO) ||
              ((bus.req_f ^ bus.req_g) == IDX_W'(1));
    is_f    = (bus.req_f == bus.req_g) ||
              (bus.req_g == BDD_ONE);
    is_g    = (bus.req_f == BDD_ONE);
    hit     = is_zero || is_f || is_g;
    if (is_zero)   term_val = BDD_ZERO;
    else if (is_f) term_val = bus.req_f;
    else           term_val = bus.req_g;
    if (bus.req_f < bus.req_g) begin
      lo_idx = bus.req_f;
      hi_idx = bus.req_g;
    end else begin
      lo_idx = bus.req_g;
      hi_idx = bus.req_f;
    end
  end

  always_comb begin
    state_d     = state_q;
    res_value_d = res_value_q;
    res_tag_d   = res_tag_q;
    miss_f_d    = miss_f_q;
    miss_g_d    = miss_g_q;
    miss_tag_d  = miss_tag_q;
    if (req_fire) begin
      if (hit) begin
        state_d     = RES_PEND;
        res_value_d = term_val;
        res_tag_d   = bus.req_tag;
      end else begin
        state_d    = MISS_PEND;
        miss_f_d   = lo_idx;
        miss_g_d   = hi_idx;
        miss_tag_d = bus.req_tag;
      end
    end else if (res_fire || miss_fire) begin
      state_d = EMPTY;
    end
  end

  // clear wins over a same-cycle increment; counts stick at all-ones
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (bus.cnt_clear) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (req_fire) begin
      if (hit && (hit_cnt_q != '1))
        hit_cnt_d = hit_cnt_q + CNT_W'(1);
      if (!hit && (miss_cnt_q != '1))
        miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      res_value_q <= '0;
      res_tag_q   <= '0;
      miss_f_q    <= '0;
      miss_g_q    <= '0;
      miss_tag_q  <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      res_value_q <= res_value_d;
      res_tag_q   <= res_tag_d;
      miss_f_q    <= miss_f_d;
      miss_g_q    <= miss_g_d;
      miss_tag_q  <= miss_tag_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.res_valid  = (state_q == RES_PEND);
  assign bus.res_value  = res_value_q;
  assign bus.res_tag    = res_tag_q;
  assign bus.miss_valid = (state_q == MISS_PEND);
  assign bus.miss_f     = miss_f_q;
  assign bus.miss_g     = miss_g_q;
  assign bus.miss_tag   = miss_tag_q;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;

endmodule

// File: tb/tb_and_request_dispatch.sv
// Directed bench for and_request_dispatch (CNT_W=4 build so
// saturation is reachable quickly).
module tb_and_request_dispatch;

  localparam int IDX_W = 30;
  localparam int TAG_W = 8;
  localparam int CNT_W = 4;
  localparam logic [IDX_W-1:0] ZERO = 30'h0;
  localparam logic [IDX_W-1:0] ONE  = 30'h1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  and_request_dispatch_if #(
    .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) ifc ();

  and_request_dispatch #(
    .IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [IDX_W-1:0] f,
                       input logic [IDX_W-1:0] g,
                       input logic [TAG_W-1:0] t);
    ifc.req_valid = 1'b1;
    ifc.req_f     = f;
    ifc.req_g     = g;
    ifc.req_tag   = t;
  endtask

  task automatic test_reset;
    reset          = 1'b1;
    ifc.req_valid  = 1'b0;
    ifc.req_f      = '0;
    ifc.req_g      = '0;
    ifc.req_tag    = '0;
    ifc.res_ready  = 1'b1;
    ifc.miss_ready = 1'b1;
    ifc.cnt_clear  = 1'b0;
    tick();
    tick();
    checks++;
    if (ifc.res_valid !== 1'b0 || ifc.miss_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got res=%b miss=%b exp 0 0",
               ifc.res_valid, ifc.miss_valid);
    end
    checks++;
    if (ifc.hit_count !== 4'h0 || ifc.miss_count !== 4'h0) begin
      errors++;
      $display("FAIL rst_cnt: got %h %h exp 0 0",
               ifc.hit_count, ifc.miss_count);
    end
    checks++;
    if (ifc.res_value !== 30'h0 || ifc.miss_f !== 30'h0) begin
      errors++;
      $display("FAIL rst_data: got %h %h exp 0 0",
               ifc.res_value, ifc.miss_f);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (ifc.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready: got %b exp 1", ifc.req_ready);
    end
  endtask

  task automatic test_hit_zero;
    drive(30'h5, ZERO, 8'h03);
    tick();
    ifc.req_valid = 1'b0;
    checks++;
    if (ifc.res_valid !== 1'b1 || ifc.miss_valid !== 1'b0) begin
      errors++;
      $display("FAIL hz_valid: got res=%b miss=%b exp 1 0",
               ifc.res_valid, ifc.miss_valid);
    end
    checks++;
    if (ifc.res_value !== ZERO || ifc.res_tag !== 8'h03) begin
      errors++;
      $display("FAIL hz_data: got %h/%h exp 0/03",
               ifc.res_value, ifc.res_tag);
    end
    checks++;
    if (ifc.hit_count !== 4'h1) begin
      errors++;
      $display("FAIL hz_cnt: got %h exp 1", ifc.hit_count);
    end
    tick();
    checks++;
    if (ifc.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL hz_drain: got %b exp 0", ifc.res_valid);
    end
  endtask

  task automatic test_miss;
    drive(30'h40, 30'h20, 8'h07);
    tick();
    ifc.req_valid = 1'b0;
    checks++;
    if (ifc.miss_valid !== 1'b1 || ifc.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL ms_valid: got miss=%b res=%b exp 1 0",
               ifc.miss_valid, ifc.res_valid);
    end
    checks++;
    if (ifc.miss_f !== 30'h20 || ifc.miss_g !== 30'h40 ||
        ifc.miss_tag !== 8'h07) begin
      errors++;
      $display("FAIL ms_data: got %h %h %h exp 20 40 07",
               ifc.miss_f, ifc.miss_g, ifc.miss_tag);
    end
    checks++;
    if (ifc.miss_count !== 4'h1) begin
      errors++;
      $display("FAIL ms_cnt: got %h exp 1", ifc.miss_count);
    end
    tick();
  endtask

  task automatic test_terminals;
    logic [IDX_W-1:0] vf [7];
    logic [IDX_W-1:0] vg [7];
    logic [IDX_W-1:0] ve [7];
    vf[0] = ONE;    vg[0] = 30'h7;  ve[0] = 30'h7;
    vf[1] = 30'h9;  vg[1] = 30'h9;  ve[1] = 30'h9;
    vf[2] = ONE;    vg[2] = ZERO;   ve[2] = ZERO;
    vf[3] = 30'h6;  vg[3] = 30'h7;  ve[3] = ZERO;
    vf[4] = 30'h13; vg[4] = ONE;    ve[4] = 30'h13;
    vf[5] = ONE;    vg[5] = ONE;    ve[5] = ONE;
    vf[6] = 30'h2A; vg[6] = ZERO;   ve[6] = ZERO;
    for (int i = 0; i < 7; i++) begin
      drive(vf[i], vg[i], 8'(8'h10 + i));
      tick();
      ifc.req_valid = 1'b0;
      checks++;
      if (ifc.res_valid !== 1'b1 || ifc.res_value !== ve[i] ||
          ifc.res_tag !== 8'(8'h10 + i)) begin
        errors++;
        $display("FAIL term%0d: got v=%b %h tag %h exp 1 %h %h",
                 i, ifc.res_valid, ifc.res_value, ifc.res_tag,
                 ve[i], 8'(8'h10 + i));
      end
      tick();
    end
    checks++;
    if (ifc.hit_count !== 4'h8) begin
      errors++;
      $display("FAIL term_cnt: got %h exp 8", ifc.hit_count);
    end
  endtask

  task automatic test_stall;
    ifc.miss_ready = 1'b0;
    drive(30'h22, 30'h11, 8'h21);
    tick();
    drive(30'h8, ZERO, 8'h22);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ifc.req_ready !== 1'b0 || ifc.miss_valid !== 1'b1 ||
          ifc.miss_f !== 30'h11 || ifc.miss_g !== 30'h22 ||
          ifc.miss_tag !== 8'h21) begin
        errors++;
        $display("FAIL stall%0d: rdy=%b v=%b %h %h %h exp 0 1 11 22 21",
                 i, ifc.req_ready, ifc.miss_valid, ifc.miss_f,
                 ifc.miss_g, ifc.miss_tag);
      end
      tick();
    end
    ifc.miss_ready = 1'b1;
    #1;
    checks++;
    if (ifc.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_rel: got %b exp 1", ifc.req_ready);
    end
    tick();
    ifc.req_valid = 1'b0;
    checks++;
    if (ifc.res_valid !== 1'b1 || ifc.miss_valid !== 1'b0 ||
        ifc.res_tag !== 8'h22 || ifc.res_value !== ZERO) begin
      errors++;
      $display("FAIL stall_next: res=%b miss=%b tag=%h val=%h exp 1 0 22 0",
               ifc.res_valid, ifc.miss_valid, ifc.res_tag,
               ifc.res_value);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    ifc.cnt_clear = 1'b1;
    tick();
    ifc.cnt_clear = 1'b0;
    checks++;
    if (ifc.hit_count !== 4'h0 || ifc.miss_count !== 4'h0) begin
      errors++;
      $display("FAIL clr: got %h %h exp 0 0",
               ifc.hit_count, ifc.miss_count);
    end
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) drive(ONE, 30'(30'h100 + i), 8'(8'h40 + i));
      else drive(30'(30'h300 + i), 30'(30'h200 + i), 8'(8'h40 + i));
      #1;
      checks++;
      if (ifc.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_rdy%0d: got %b exp 1", i, ifc.req_ready);
      end
      tick();
      checks++;
      if (i % 2 == 0) begin
        if (ifc.res_valid !== 1'b1 ||
            ifc.res_value !== 30'(30'h100 + i) ||
            ifc.res_tag !== 8'(8'h40 + i)) begin
          errors++;
          $display("FAIL b2b_hit%0d: v=%b %h %h exp 1 %h %h", i,
                   ifc.res_valid, ifc.res_value, ifc.res_tag,
                   30'(30'h100 + i), 8'(8'h40 + i));
        end
      end else begin
        if (ifc.miss_valid !== 1'b1 ||
            ifc.miss_f !== 30'(30'h200 + i) ||
            ifc.miss_g !== 30'(30'h300 + i) ||
            ifc.miss_tag !== 8'(8'h40 + i)) begin
          errors++;
          $display("FAIL b2b_miss%0d: v=%b %h %h %h exp 1 %h %h %h", i,
                   ifc.miss_valid, ifc.miss_f, ifc.miss_g,
                   ifc.miss_tag, 30'(30'h200 + i),
                   30'(30'h300 + i), 8'(8'h40 + i));
        end
      end
    end
    ifc.req_valid = 1'b0;
    checks++;
    if (ifc.hit_count !== 4'h5 || ifc.miss_count !== 4'h5) begin
      errors++;
      $display("FAIL b2b_cnt: got %h %h exp 5 5",
               ifc.hit_count, ifc.miss_count);
    end
    tick();
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 10; i++) begin
      drive(30'(30'h400 + 2 * i), 30'h800, 8'(i));
      tick();
    end
    checks++;
    if (ifc.miss_count !== 4'hF) begin
      errors++;
      $display("FAIL sat_full: got %h exp f", ifc.miss_count);
    end
    drive(30'h900, 30'h700, 8'h5A);
    tick();
    checks++;
    if (ifc.miss_count !== 4'hF || ifc.hit_count !== 4'h5) begin
      errors++;
      $display("FAIL sat_hold: got %h %h exp f 5",
               ifc.miss_count, ifc.hit_count);
    end
    drive(30'h910, 30'h720, 8'h5B);
    ifc.cnt_clear = 1'b1;
    tick();
    ifc.cnt_clear = 1'b0;
    ifc.req_valid = 1'b0;
    checks++;
    if (ifc.miss_count !== 4'h0 || ifc.hit_count !== 4'h0 ||
        ifc.miss_valid !== 1'b1 || ifc.miss_tag !== 8'h5B) begin
      errors++;
      $display("FAIL sat_clr: got %h %h v=%b tag=%h exp 0 0 1 5b",
               ifc.miss_count, ifc.hit_count, ifc.miss_valid,
               ifc.miss_tag);
    end
    tick();
  endtask

  task automatic test_reset_pending;
    ifc.res_ready = 1'b0;
    drive(ONE, 30'h55, 8'h77);
    tick();
    ifc.req_valid = 1'b0;
    checks++;
    if (ifc.res_valid !== 1'b1 || ifc.res_value !== 30'h55) begin
      errors++;
      $display("FAIL rp_load: got %b %h exp 1 55",
               ifc.res_valid, ifc.res_value);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ifc.res_valid !== 1'b0 || ifc.res_value !== 30'h0 ||
        ifc.res_tag !== 8'h0 || ifc.hit_count !== 4'h0) begin
      errors++;
      $display("FAIL rp_async: got %b %h %h %h exp 0 0 0 0",
               ifc.res_valid, ifc.res_value, ifc.res_tag,
               ifc.hit_count);
    end
    tick();
    reset = 1'b0;
    ifc.res_ready = 1'b1;
    #1;
    checks++;
    if (ifc.req_ready !== 1'b1 || ifc.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL rp_after: rdy=%b v=%b exp 1 0",
               ifc.req_ready, ifc.res_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_hit_zero();
    test_miss();
    test_terminals();
    test_stall();
    test_back_to_back();
    test_saturate();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
